mem_access_unit: RTL and testbench

// Parametrised successor to the pipeline's fixed-latency MEM stage. Sits between EXE and WB.

---
 rtl/mau_pkg.sv | 21 ++
 rtl/mau_lane.sv | 64 ++++++
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: exception codes, access sizes
// and the request FSM states.
package mau_pkg;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_ADEL   = 2'b01;
  localparam logic [1:0] EXC_ADES   = 2'b10;
  localparam logic [1:0] EXC_BUSERR = 2'b11;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mau_lane.sv
// Byte-lane logic for the memory access unit: store strobes, store data
// replication and load lane extraction with zero/sign extension.
module mau_lane
  import mau_pkg::*;
#(
  parameter  int DW  = 32,
  localparam int SBW = DW / 8,
  localparam int LW  = $clog2(SBW)
) (
  input  logic [1:0]    size,
  input  logic [LW-1:0] addr_lo,
  input  logic          sign,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic [SBW-1:0] wstrb,
  output logic [DW-1:0] wdata_rep,
  output logic [DW-1:0] ldata
);

  function automatic logic [DW-1:0] extend(input logic [DW-1:0] v,
                                           input logic [DW-1:0] m,
                                           input logic          s);
    return (v & m) | (s ? ~m : '0);
  endfunction

  logic [SBW-1:0] base;
  logic [DW-1:0]  shifted;
  logic [DW-1:0]  mask;
  logic           msb;
  int             rep_mask;

  always_comb begin
    base     = '0;
    rep_mask = 0;
    case (size)
      SZ_BYTE: begin base = SBW'(8'h01); rep_mask = 0; end
      SZ_HALF: begin base = SBW'(8'h03); rep_mask = 1; end
      SZ_WORD: begin base = SBW'(8'h0f); rep_mask = 3; end
      default: begin base = '1;          rep_mask = 7; end
    endcase
    wstrb = base << addr_lo;
  end

  // Each destination byte takes the source byte at the same offset within the access width
  always_comb begin
    wdata_rep = '0;
    for (int i = 0; i < SBW; i++)
      wdata_rep[8*i +: 8] = wdata[8*(i & rep_mask) +: 8];
  end

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    mask    = '1;
    msb     = shifted[DW-1];
    case (size)
      SZ_BYTE: begin mask = DW'(8'hff);         msb = shifted[7];  end
      SZ_HALF: begin mask = DW'(16'hffff);      msb = shifted[15]; end
      SZ_WORD: begin mask = DW'(32'hffff_ffff); msb = shifted[31]; end
      default: begin mask = '1;                 msb = shifted[DW-1]; end
    endcase
    ldata = extend(shifted, mask, sign && msb);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage with a variable-latency req/ack data memory port: address remap,
// alignment faults, lane steering, load extension and a bus timeout.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter  int          DW       = 32,
  parameter  int          AW       = 32,
  parameter  logic [15:0] CONF_HI  = 16'hbfaf,
  parameter  int          MAX_WAIT = 16,
  localparam int          SBW      = DW / 8,
  localparam int          LW       = $clog2(SBW),
  localparam int          CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_ld,
  input  logic           in_st,
  input  logic [1:0]     in_size,
  input  logic           in_sign,
  input  logic [AW-1:0]  in_addr,
  input  logic [DW-1:0]  in_wdata,
  input  logic [4:0]     in_dest,
  input  logic           flush,
  output logic           dm_req,
  output logic           dm_we,
  output logic [AW-1:0]  dm_addr,
  output logic [SBW-1:0] dm_wstrb,
  output logic [DW-1:0]  dm_wdata,
  input  logic           dm_ack,
  input  logic [DW-1:0]  dm_rdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_result,
  output logic [4:0]     out_dest,
  output logic [1:0]     out_exc,
  output logic [AW-1:0]  out_badaddr,
  output logic [4:0]     busy_dest
);

  function automatic logic [AW-1:0] remap(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    if (a[31:16] == CONF_HI)    r[31:28] = 4'h1;
    else if (a[31:30] == 2'b10) r[31:29] = 3'b000;
    return r;
  endfunction

  state_e        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          timeout;
  logic          killed;
  logic          ld_q;
  logic          sign_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [4:0]    dest_q;

  logic          is_mem;
  logic          misal;
  logic [1:0]    lane_size;
  logic [LW-1:0] lane_addr;
  logic [SBW-1:0] lane_wstrb;
  logic [DW-1:0] lane_wdata;
  logic [DW-1:0] lane_ldata;

  assign is_mem = in_ld | in_st;

  always_comb begin
    case (in_size)
      SZ_BYTE: misal = 1'b0;
      SZ_HALF: misal = in_addr[0];
      SZ_WORD: misal = |in_addr[1:0];
      default: misal = (DW != 64) || (|in_addr[2:0]);
    endcase
  end

  // The lane logic serves the incoming op in IDLE and the held op while waiting for ack
  assign lane_size = (state == S_IDLE) ? in_size : size_q;
  assign lane_addr = (state == S_IDLE) ? in_addr[LW-1:0] : addr_q[LW-1:0];

  mau_lane #(.DW(DW)) u_lane (
    .size      (lane_size),
    .addr_lo   (lane_addr),
    .sign      (sign_q),
    .wdata     (in_wdata),
    .rdata     (dm_rdata),
    .wstrb     (lane_wstrb),
    .wdata_rep (lane_wdata),
    .ldata     (lane_ldata)
  );

  assign wait_nxt = (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
  assign timeout  = (wait_nxt == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      wait_cnt    <= '0;
      killed      <= 1'b0;
      ld_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      dest_q      <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wstrb    <= '0;
      dm_wdata    <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_dest    <= '0;
      out_exc     <= EXC_NONE;
      out_badaddr <= '0;
      busy_dest   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            in_ready  <= 1'b0;
            busy_dest <= in_dest;
            ld_q      <= in_ld;
            sign_q    <= in_sign;
            size_q    <= in_size;
            addr_q    <= in_addr;
            dest_q    <= in_dest;
            killed    <= 1'b0;
            if (is_mem && !misal) begin
              state    <= S_REQ;
              wait_cnt <= '0;
              dm_req   <= 1'b1;
              dm_we    <= in_st && !in_ld;
              dm_addr  <= remap(in_addr);
              dm_wstrb <= (in_st && !in_ld) ? lane_wstrb : '0;
              dm_wdata <= (in_st && !in_ld) ? lane_wdata : '0;
            end else begin
              // Pass-through result, or an alignment fault that never reaches memory
              state       <= S_RESP;
              out_valid   <= 1'b1;
              out_exc     <= !is_mem ? EXC_NONE : (in_ld ? EXC_ADEL : EXC_ADES);
              out_dest    <= is_mem ? 5'd0 : in_dest;
              out_result  <= is_mem ? '0 : DW'(in_addr);
              out_badaddr <= is_mem ? in_addr : '0;
            end
          end
        end
        S_REQ: begin
          if (flush) killed <= 1'b1;
          wait_cnt <= wait_nxt;
          if (dm_ack || timeout) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wstrb <= '0;
            dm_wdata <= '0;
            if (killed || flush) begin
              state     <= S_IDLE;
              in_ready  <= 1'b1;
              busy_dest <= '0;
            end else begin
              state       <= S_RESP;
              out_valid   <= 1'b1;
              out_exc     <= dm_ack ? EXC_NONE : EXC_BUSERR;
              out_dest    <= dm_ack ? dest_q : 5'd0;
              out_result  <= (dm_ack && ld_q) ? lane_ldata : '0;
              out_badaddr <= dm_ack ? '0 : addr_q;
            end
          end
        end
        default: begin
          if (flush || out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy_dest <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one DW=32 and one DW=64 instance
// sharing stimulus, selected per transaction.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel64 = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ld = 1'b0, in_st = 1'b0, in_sign = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic [31:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic [4:0]  in_dest = '0;
  logic        flush = 1'b0;
  logic        dm_ack = 1'b0;
  logic [63:0] dm_rdata = '0;
  logic        out_ready = 1'b0;

  logic        iv_a, iv_b;
  logic        in_ready_a, in_ready_b;
  logic        dm_req_a, dm_req_b, dm_we_a, dm_we_b;
  logic [31:0] dm_addr_a, dm_addr_b;
  logic [3:0]  dm_wstrb_a;
  logic [7:0]  dm_wstrb_b;
  logic [31:0] dm_wdata_a;
  logic [63:0] dm_wdata_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] out_result_a;
  logic [63:0] out_result_b;
  logic [4:0]  out_dest_a, out_dest_b, busy_dest_a, busy_dest_b;
  logic [1:0]  out_exc_a, out_exc_b;
  logic [31:0] out_badaddr_a, out_badaddr_b;

  int n_checks = 0;
  int n_errors = 0;
  int nreq;

  always #5 clk = ~clk;

  assign iv_a = in_valid & ~sel64;
  assign iv_b = in_valid & sel64;

  mem_access_unit #(.DW(32), .AW(32), .MAX_WAIT(16)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(iv_a), .in_ready(in_ready_a),
    .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_sign(in_sign),
    .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .in_dest(in_dest), .flush(flush),
    .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wstrb(dm_wstrb_a),
    .dm_wdata(dm_wdata_a), .dm_ack(dm_ack), .dm_rdata(dm_rdata[31:0]),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_result(out_result_a),
    .out_dest(out_dest_a), .out_exc(out_exc_a), .out_badaddr(out_badaddr_a),
    .busy_dest(busy_dest_a)
  );

  mem_access_unit #(.DW(64), .AW(32), .MAX_WAIT(16)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(iv_b), .in_ready(in_ready_b),
    .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_sign(in_sign),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_dest(in_dest), .flush(flush),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wstrb(dm_wstrb_b),
    .dm_wdata(dm_wdata_b), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_result(out_result_b),
    .out_dest(out_dest_b), .out_exc(out_exc_b), .out_badaddr(out_badaddr_b),
    .busy_dest(busy_dest_b)
  );

  logic        v_in_ready, v_dm_req, v_dm_we, v_out_valid;
  logic [31:0] v_dm_addr, v_out_badaddr;
  logic [7:0]  v_dm_wstrb;
  logic [63:0] v_dm_wdata, v_out_result;
  logic [4:0]  v_out_dest, v_busy_dest;
  logic [1:0]  v_out_exc;

  assign v_in_ready    = sel64 ? in_ready_b    : in_ready_a;
  assign v_dm_req      = sel64 ? dm_req_b      : dm_req_a;
  assign v_dm_we       = sel64 ? dm_we_b       : dm_we_a;
  assign v_dm_addr     = sel64 ? dm_addr_b     : dm_addr_a;
  assign v_dm_wstrb    = sel64 ? dm_wstrb_b    : {4'h0, dm_wstrb_a};
  assign v_dm_wdata    = sel64 ? dm_wdata_b    : {32'h0, dm_wdata_a};
  assign v_out_valid   = sel64 ? out_valid_b   : out_valid_a;
  assign v_out_result  = sel64 ? out_result_b  : {32'h0, out_result_a};
  assign v_out_dest    = sel64 ? out_dest_b    : out_dest_a;
  assign v_out_exc     = sel64 ? out_exc_b     : out_exc_a;
  assign v_out_badaddr = sel64 ? out_badaddr_b : out_badaddr_a;
  assign v_busy_dest   = sel64 ? busy_dest_b   : busy_dest_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns at the negedge after the accept edge
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [63:0] wd, input logic [4:0] d);
    in_ld = ld; in_st = st; in_size = sz; in_sign = sg;
    in_addr = a; in_wdata = wd; in_dest = d; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles with dm_req high; raises dm_ack during the ack_on-th one (0 = never)
  task automatic mem_wait(input int ack_on, input logic [63:0] rd, output int cnt);
    cnt = 0;
    for (int c = 0; c < 40 && v_dm_req; c++) begin
      cnt++;
      if (cnt == ack_on) begin dm_ack = 1'b1; dm_rdata = rd; end
      @(posedge clk); @(negedge clk);
      dm_ack = 1'b0;
    end
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready"}, v_in_ready, 1);
    check({tag, "_out_valid"}, v_out_valid, 0);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", v_in_ready, 1);
    check("rst_dm_req", v_dm_req, 0);
    check("rst_out_valid", v_out_valid, 0);
    check("rst_busy_dest", v_busy_dest, 0);
    resetn = 1'b1;
    @(negedge clk);

    // SW through kseg remap, ack on the third request cycle
    issue(0, 1, 2'b10, 0, 32'h8000_1004, 64'h1122_3344, 5'd0);
    check("sw_addr", v_dm_addr, 32'h0000_1004);
    check("sw_wstrb", v_dm_wstrb, 8'h0f);
    check("sw_wdata", v_dm_wdata, 64'h1122_3344);
    check("sw_we", v_dm_we, 1);
    check("sw_in_ready", v_in_ready, 0);
    mem_wait(3, 64'h0, nreq);
    check("sw_req_cycles", nreq, 3);
    check("sw_out_valid", v_out_valid, 1);
    check("sw_exc", v_out_exc, 2'b00);
    retire("sw");

    // LB / LBU / LH loads with zero-wait ack
    issue(1, 0, 2'b00, 1, 32'h0000_0003, 64'h0, 5'd5);
    check("lb_busy_dest", v_busy_dest, 5);
    check("lb_wstrb", v_dm_wstrb, 0);
    mem_wait(1, 64'h80FF_0000, nreq);
    check("lb_req_cycles", nreq, 1);
    check("lb_result", v_out_result, 64'hFFFF_FF80);
    check("lb_dest", v_out_dest, 5);
    retire("lb");
    issue(1, 0, 2'b00, 0, 32'h0000_0003, 64'h0, 5'd5);
    mem_wait(1, 64'h80FF_0000, nreq);
    check("lbu_result", v_out_result, 64'h0000_0080);
    retire("lbu");
    issue(1, 0, 2'b01, 1, 32'h0000_0002, 64'h0, 5'd6);
    mem_wait(1, 64'h80FF_0000, nreq);
    check("lh_result", v_out_result, 64'hFFFF_80FF);
    retire("lh");

    // Narrow stores: strobe placement and lane replication
    issue(0, 1, 2'b00, 0, 32'h0000_0002, 64'hAB, 5'd0);
    check("sb_wstrb", v_dm_wstrb, 8'h04);
    check("sb_wdata", v_dm_wdata, 64'hABAB_ABAB);
    mem_wait(1, 64'h0, nreq);
    retire("sb");
    issue(0, 1, 2'b01, 0, 32'h0000_0002, 64'h1234, 5'd0);
    check("sh_wstrb", v_dm_wstrb, 8'h0c);
    check("sh_wdata", v_dm_wdata, 64'h1234_1234);
    mem_wait(1, 64'h0, nreq);
    retire("sh");

    // Alignment faults and pass-through
    issue(1, 0, 2'b01, 0, 32'h0000_0001, 64'h0, 5'd7);
    check("lh_mis_req", v_dm_req, 0);
    check("lh_mis_valid", v_out_valid, 1);
    check("lh_mis_exc", v_out_exc, 2'b01);
    check("lh_mis_badaddr", v_out_badaddr, 32'h0000_0001);
    check("lh_mis_dest", v_out_dest, 0);
    retire("lh_mis");
    issue(0, 1, 2'b10, 0, 32'h0000_0002, 64'h0, 5'd0);
    check("sw_mis_exc", v_out_exc, 2'b10);
    retire("sw_mis");
    issue(1, 0, 2'b11, 0, 32'h0000_0000, 64'h0, 5'd4);
    check("ld32_exc", v_out_exc, 2'b01);
    check("ld32_req", v_dm_req, 0);
    retire("ld32");
    issue(0, 0, 2'b10, 0, 32'hDEAD_BEEF, 64'h0, 5'd9);
    check("pt_valid", v_out_valid, 1);
    check("pt_result", v_out_result, 64'hDEAD_BEEF);
    check("pt_dest", v_out_dest, 9);
    check("pt_req", v_dm_req, 0);
    @(negedge clk);
    check("pt_hold_valid", v_out_valid, 1);
    check("pt_hold_result", v_out_result, 64'hDEAD_BEEF);
    retire("pt");

    // Config-window remap with no ack: bus timeout
    issue(1, 0, 2'b10, 0, 32'hBFAF_0010, 64'h0, 5'd8);
    check("to_addr", v_dm_addr, 32'h1FAF_0010);
    mem_wait(0, 64'h0, nreq);
    check("to_req_cycles", nreq, 16);
    check("to_valid", v_out_valid, 1);
    check("to_exc", v_out_exc, 2'b11);
    check("to_badaddr", v_out_badaddr, 32'hBFAF_0010);
    check("to_dest", v_out_dest, 0);
    retire("to");

    // Flush during REQ: request held until ack on its fourth cycle, then dropped silently
    issue(1, 0, 2'b10, 0, 32'h0000_0100, 64'h0, 5'd3);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check("fl_req2", v_dm_req, 1);
    @(negedge clk);
    check("fl_req3", v_dm_req, 1);
    @(negedge clk);
    check("fl_req4", v_dm_req, 1);
    dm_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dm_ack = 1'b0;
    check("fl_req_drop", v_dm_req, 0);
    check("fl_no_valid", v_out_valid, 0);
    check("fl_in_ready", v_in_ready, 1);

    // Flush in RESP, and flush together with in_valid
    issue(0, 0, 2'b10, 0, 32'h0000_0042, 64'h0, 5'd2);
    check("flr_valid", v_out_valid, 1);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    check("flr_drop", v_out_valid, 0);
    check("flr_ready", v_in_ready, 1);
    issue(0, 0, 2'b10, 0, 32'h0000_0043, 64'h0, 5'd2);
    flush = 1'b0;
    check("flv_ready", v_in_ready, 1);
    check("flv_valid", v_out_valid, 0);

    // Asynchronous reset while a request is outstanding
    issue(1, 0, 2'b10, 0, 32'h0000_0020, 64'h0, 5'd1);
    check("arst_pre", v_dm_req, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_req", v_dm_req, 0);
    check("arst_ready", v_in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // 64-bit instance: SD then sign-extended LW from the upper word
    sel64 = 1'b1;
    issue(0, 1, 2'b11, 0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 5'd0);
    check("sd_wstrb", v_dm_wstrb, 8'hff);
    check("sd_wdata", v_dm_wdata, 64'h0123_4567_89AB_CDEF);
    check("sd_addr", v_dm_addr, 32'h0000_0008);
    mem_wait(1, 64'h0, nreq);
    check("sd_exc", v_out_exc, 2'b00);
    retire("sd");
    issue(1, 0, 2'b10, 1, 32'h0000_000C, 64'h0, 5'd11);
    check("lw64_wstrb", v_dm_wstrb, 8'h00);
    mem_wait(1, 64'hF000_0000_1234_5678, nreq);
    check("lw64_result", v_out_result, 64'hFFFF_FFFF_F000_0000);
    @(negedge clk);
    check("lw64_hold1", v_out_result, 64'hFFFF_FFFF_F000_0000);
    check("lw64_hold1_valid", v_out_valid, 1);
    @(negedge clk);
    check("lw64_hold2", v_out_result, 64'hFFFF_FFFF_F000_0000);
    check("lw64_dest", v_out_dest, 11);
    retire("lw64");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
